pipeline_mem_arbiter: RTL

PIPELINE_MEM_ARBITER -- requirements
Module: pipeline_mem_arbiter

---
 rtl/pipeline_mem_arb_pkg.sv | 33 +++
 rtl/pipeline_mem_arb_pick.sv | 29 ++
 rtl/pipeline_mem_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_mem_arb_pkg.sv
// Shared types and constants for the pipeline memory arbiter.
// Holds the arbiter state enum, the grant payload, the control-field
// widths and encodings, and a helper that flags a no-op data request.
package pipeline_mem_arb_pkg;

    localparam int unsigned RD_CTRL_W = 3;
    localparam int unsigned WR_CTRL_W = 2;

    localparam logic [RD_CTRL_W-1:0] RD_NONE    = 3'b000;
    localparam logic [WR_CTRL_W-1:0] WR_NONE    = 2'b00;
    // Word-read encoding used for every instruction fetch.
    localparam logic [RD_CTRL_W-1:0] IF_RD_CTRL = 3'b010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        NOP_DM  = 2'd3
    } arb_state_e;

    // One-hot grant: at most one field set.
    typedef struct packed {
        logic dm;
        logic fetch;
    } grant_t;

    // A data request with neither load nor store needs no memory command.
    function automatic logic is_dm_nop(input logic [RD_CTRL_W-1:0] rd_ctrl,
                                       input logic [WR_CTRL_W-1:0] wr_ctrl);
        return (rd_ctrl == RD_NONE) && (wr_ctrl == WR_NONE);
    endfunction

endpackage

// File: rtl/pipeline_mem_arb_pick.sv
// Grant selection between the fetch and data ports.
// Ports:
//   req_if_i   - fetch port is eligible this cycle
//   req_dm_i   - data port is eligible this cycle
//   last_dm_i  - 1 when the data port received the most recent grant
//   grant_c_o  - combinational one-hot grant
// On a tie the port not granted last wins; tying last_dm_i low gives
// fixed data-port priority.
module pipeline_mem_arb_pick
    import pipeline_mem_arb_pkg::*;
(
    input  logic   req_if_i,
    input  logic   req_dm_i,
    input  logic   last_dm_i,
    output grant_t grant_c_o
);

    always_comb begin
        grant_c_o = '0;
        if (req_if_i && req_dm_i) begin
            grant_c_o.dm    = ~last_dm_i;
            grant_c_o.fetch = last_dm_i;
        end else begin
            grant_c_o.dm    = req_dm_i;
            grant_c_o.fetch = req_if_i;
        end
    end

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// Arbitrates a single shared memory between the instruction-fetch port and
// the data (MEM stage) port of a pipeline.
// Ports:
//   clk, reset                 - clock, asynchronous active-low reset
//   if_req/if_addr             - fetch request (held until if_ack)
//   if_rdata/if_ack            - fetch data and one-cycle completion pulse
//   dm_req/dm_addr/dm_wdata    - data request, address, store data
//   dm_rd_ctrl/dm_wr_ctrl      - load / store control (0 = none)
//   dm_rdata/dm_ack            - load data and one-cycle completion pulse
//   stall                      - combinational pipeline freeze request
//   mem_valid/mem_ready        - command handshake to shared memory
//   mem_addr/mem_din           - command address and store data
//   mem_rd_ctrl/mem_wr_ctrl    - command controls
//   mem_dout                   - memory read data (valid with mem_ready)
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// the data port has fixed priority and no grant pointer is built.
module pipeline_mem_arbiter
    import pipeline_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_req,
    input  logic [ADDR_W-1:0]    if_addr,
    output logic [DATA_W-1:0]    if_rdata,
    output logic                 if_ack,
    input  logic                 dm_req,
    input  logic [ADDR_W-1:0]    dm_addr,
    input  logic [DATA_W-1:0]    dm_wdata,
    input  logic [RD_CTRL_W-1:0] dm_rd_ctrl,
    input  logic [WR_CTRL_W-1:0] dm_wr_ctrl,
    output logic [DATA_W-1:0]    dm_rdata,
    output logic                 dm_ack,
    output logic                 stall,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_din,
    output logic [RD_CTRL_W-1:0] mem_rd_ctrl,
    output logic [WR_CTRL_W-1:0] mem_wr_ctrl,
    input  logic [DATA_W-1:0]    mem_dout
);

    arb_state_e           state_q,       state_d;
    logic                 mem_valid_q,   mem_valid_d;
    logic [ADDR_W-1:0]    mem_addr_q,    mem_addr_d;
    logic [DATA_W-1:0]    mem_din_q,     mem_din_d;
    logic [RD_CTRL_W-1:0] mem_rd_ctrl_q, mem_rd_ctrl_d;
    logic [WR_CTRL_W-1:0] mem_wr_ctrl_q, mem_wr_ctrl_d;
    logic                 if_ack_q,      if_ack_d;
    logic                 dm_ack_q,      dm_ack_d;
    logic [DATA_W-1:0]    if_rdata_q,    if_rdata_d;
    logic [DATA_W-1:0]    dm_rdata_q,    dm_rdata_d;

    logic   in_idle;
    logic   elig_if;
    logic   elig_dm;
    logic   last_dm;
    grant_t grant;

    // A port whose ack is showing still has its old req high; skip it.
    assign in_idle = (state_q == IDLE);
    assign elig_if = in_idle & if_req & ~if_ack_q;
    assign elig_dm = in_idle & dm_req & ~dm_ack_q;

    pipeline_mem_arb_pick u_pick (
        .req_if_i  (elig_if),
        .req_dm_i  (elig_dm),
        .last_dm_i (last_dm),
        .grant_c_o (grant)
    );

`ifdef MEM_ARB_RR_EN
    logic last_dm_q, last_dm_d;

    // Grant pointer: remembers which port was granted most recently.
    always_comb begin
        last_dm_d = last_dm_q;
        if (grant.dm) begin
            last_dm_d = 1'b1;
        end else if (grant.fetch) begin
            last_dm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_dm_q <= 1'b0;
        end else begin
            last_dm_q <= last_dm_d;
        end
    end

    assign last_dm = last_dm_q;
`else
    // Pretending the fetch port was granted last makes the data port win ties.
    assign last_dm = 1'b0;
`endif

    // Next-state, command and completion logic.
    always_comb begin
        state_d       = state_q;
        mem_valid_d   = mem_valid_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        mem_rd_ctrl_d = mem_rd_ctrl_q;
        mem_wr_ctrl_d = mem_wr_ctrl_q;
        if_ack_d      = 1'b0;
        dm_ack_d      = 1'b0;
        if_rdata_d    = if_rdata_q;
        dm_rdata_d    = dm_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant.dm) begin
                    if (is_dm_nop(dm_rd_ctrl, dm_wr_ctrl)) begin
                        // Nothing to send to memory; acknowledge straight away.
                        state_d  = NOP_DM;
                        dm_ack_d = 1'b1;
                    end else begin
                        state_d       = BUSY_DM;
                        mem_valid_d   = 1'b1;
                        mem_addr_d    = dm_addr;
                        mem_din_d     = dm_wdata;
                        mem_rd_ctrl_d = dm_rd_ctrl;
                        mem_wr_ctrl_d = dm_wr_ctrl;
                    end
                end else if (grant.fetch) begin
                    state_d       = BUSY_IF;
                    mem_valid_d   = 1'b1;
                    mem_addr_d    = if_addr;
                    mem_din_d     = '0;
                    mem_rd_ctrl_d = IF_RD_CTRL;
                    mem_wr_ctrl_d = WR_NONE;
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    if_ack_d    = 1'b1;
                    if_rdata_d  = mem_dout;
                end
            end
            BUSY_DM: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    dm_ack_d    = 1'b1;
                    // Stores leave the last load result in place.
                    if (mem_rd_ctrl_q != RD_NONE) begin
                        dm_rdata_d = mem_dout;
                    end
                end
            end
            NOP_DM: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            mem_valid_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_rd_ctrl_q <= RD_NONE;
            mem_wr_ctrl_q <= WR_NONE;
            if_ack_q      <= 1'b0;
            dm_ack_q      <= 1'b0;
            if_rdata_q    <= '0;
            dm_rdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            mem_valid_q   <= mem_valid_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            mem_rd_ctrl_q <= mem_rd_ctrl_d;
            mem_wr_ctrl_q <= mem_wr_ctrl_d;
            if_ack_q      <= if_ack_d;
            dm_ack_q      <= dm_ack_d;
            if_rdata_q    <= if_rdata_d;
            dm_rdata_q    <= dm_rdata_d;
        end
    end

    assign mem_valid   = mem_valid_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign mem_rd_ctrl = mem_rd_ctrl_q;
    assign mem_wr_ctrl = mem_wr_ctrl_q;
    assign if_ack      = if_ack_q;
    assign dm_ack      = dm_ack_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;

    // Freeze the pipeline while any request is still outstanding.
    assign stall = (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);

endmodule
